// File: rtl/disp_pkg.sv
// Shared constants and types for the hour display driver: code range,
// seven-segment glyphs ({g,f,e,d,c,b,a}, active-high) and digit-select encoding.
package disp_pkg;

    localparam int          MOD_HOURS = 12;
    localparam logic [3:0]  MAX_CODE  = 4'd11;

    typedef logic [6:0] seg_t;

    // One-hot digit enable: bit 0 drives the ones digit, bit 1 the tens digit.
    typedef enum logic [1:0] {
        DSEL_ONES = 2'b01,
        DSEL_TENS = 2'b10
    } dsel_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic dsel_t dsel_swap(input dsel_t d);
        return (d == DSEL_ONES) ? DSEL_TENS : DSEL_ONES;
    endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD to seven-segment encoder; any non-BCD code renders as a dash.
module seg7_enc
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/hour_disp_drv.sv
// Two-digit multiplexed 12-hour display driver fed by a MOD12 counter, with
// AM/PM tracking on natural 11->0 wraps and out-of-range code flagging.
module hour_disp_drv
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       cnt_load,
    output logic [6:0] seg,
    output logic [1:0] digit_sel,
    output logic       pm,
    output logic       err,
    output logic       err_sticky
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Stage 1: input sample and one-cycle history
    logic [3:0] cur_q, prev_q;
    logic       load_d;

    // Stage 2: decoded label
    logic       tens_q;
    logic [3:0] ones_q;
    logic       inv_q;

    logic [SCAN_W-1:0] scan_cnt;
    dsel_t             dsel_q;
    seg_t              seg_q;
    logic              pm_q;
    logic              sticky_q;

    logic       wrap_evt;
    logic       tens_d;
    logic [3:0] ones_d;
    logic       inv_d;
    logic       scan_end;
    dsel_t      dsel_nxt;
    logic [3:0] enc_in;
    seg_t       enc_out;
    seg_t       seg_nxt;

    // A wrap counts only when the counter got to 0 by itself, not via a load.
    assign wrap_evt = (prev_q == MAX_CODE) && (cur_q == 4'd0) && !load_d;

    always_comb begin
        tens_d = 1'b0;
        ones_d = 4'd0;
        inv_d  = 1'b0;
        if (cur_q >= 4'(MOD_HOURS)) begin
            inv_d = 1'b1;
        end else if (cur_q == 4'd0) begin
            tens_d = 1'b1;
            ones_d = 4'd2;
        end else if (cur_q >= 4'd10) begin
            tens_d = 1'b1;
            ones_d = cur_q - 4'd10;
        end else begin
            ones_d = cur_q;
        end
    end

    // seg is computed for the digit that will be enabled after this edge, so
    // seg and digit_sel always change together.
    assign scan_end = (scan_cnt == SCAN_LAST);
    assign dsel_nxt = scan_end ? dsel_swap(dsel_q) : dsel_q;
    assign enc_in   = (dsel_nxt == DSEL_ONES) ? ones_q : 4'd1;

    seg7_enc u_enc (
        .bcd (enc_in),
        .seg (enc_out)
    );

    always_comb begin
        seg_nxt = enc_out;
        if (inv_q)
            seg_nxt = SEG_DASH;
        else if ((dsel_nxt == DSEL_TENS) && !tens_q)
            seg_nxt = SEG_BLANK;
    end

    // NOTE: non-blocking assignments throughout, so every register samples the
    // pre-edge value of its neighbours and the pipeline stages stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= 4'd0;
            prev_q   <= 4'd0;
            load_d   <= 1'b0;
            tens_q   <= 1'b1;
            ones_q   <= 4'd2;
            inv_q    <= 1'b0;
            scan_cnt <= '0;
            dsel_q   <= DSEL_ONES;
            seg_q    <= SEG_BLANK;
            pm_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cur_q    <= count;
            prev_q   <= cur_q;
            load_d   <= cnt_load;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            inv_q    <= inv_d;
            scan_cnt <= scan_end ? '0 : scan_cnt + 1'b1;
            dsel_q   <= dsel_nxt;
            seg_q    <= seg_nxt;
            pm_q     <= pm_q ^ wrap_evt;
            sticky_q <= sticky_q | inv_q;
        end
    end

    assign seg        = seg_q;
    assign digit_sel  = dsel_q;
    assign pm         = pm_q;
    assign err        = inv_q;
    assign err_sticky = sticky_q;

endmodule
